// File: rtl/eth_tx_framer.sv
// eth_tx_framer: transmit-side Ethernet framer.
//   Accepts a flit stream (sop/eop/empty/data) from the egress pipeline,
//   repairs malformed framing (missing sop, sop inside a packet, overlong
//   packets), buffers flits in a small FIFO against eth backpressure and
//   emits one eth active message per flit with arg3 = {empty, eop, sop}.
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is registered)
//   in_sop/in_eop       framing of the input flit
//   in_empty/in_data    empty-byte count (eop flit) and flit payload
//   eth_txFull          eth sink cannot take a message this cycle
//   eth_tx              one-cycle message valid
//   eth_data/eth_arg3   message payload and framing code
//   stat_pkts           packets emitted (eop flits popped)
//   stat_drop_flits     input flits discarded
//   stat_trunc          packets closed by a forced eop
module eth_tx_framer #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_FLITS   = 24
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   eth_txFull,
  output logic                   eth_tx,
  output logic [DATA_WIDTH-1:0]  eth_data,
  output logic [7:0]             eth_arg3,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_drop_flits,
  output logic [31:0]            stat_trunc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_FLITS + 1);
  localparam logic [AW:0]   READY_MAX = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] CNT_CAP   = CW'(MAX_FLITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_hold_valid;
  logic                  r_hold_final;
  logic [7:0]            r_hold_arg3;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [DATA_WIDTH+7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_fifo_cnt;
  logic                  r_in_ready;
  logic                  r_eth_tx;
  logic [DATA_WIDTH-1:0] r_eth_data;
  logic [7:0]            r_eth_arg3;
  logic [31:0]           r_stat_pkts;
  logic [31:0]           r_stat_drop;
  logic [31:0]           r_stat_trunc;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_acc;
  logic          w_pop;
  logic          w_wr;
  logic          w_load;
  logic          w_ld_final;
  logic          w_drop;
  logic [1:0]    w_trunc_inc;
  logic [7:0]    w_in_arg3;
  logic [7:0]    w_ld_arg3;
  logic [7:0]    w_wr_arg3;
  logic [AW:0]   w_fifo_cnt_nxt;

  assign w_in_arg3 = 8'({in_empty, in_eop, in_sop});
  assign w_acc     = in_valid && r_in_ready;
  assign w_pop     = (r_fifo_cnt != '0) && !eth_txFull;
  assign w_fifo_cnt_nxt = r_fifo_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};

  // State register and packet flit count
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, hold-register load and FIFO write decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_ld_final  = 1'b0;
    w_ld_arg3   = w_in_arg3;
    w_drop      = 1'b0;
    w_trunc_inc = 2'd0;
    // A final held flit always leaves one cycle after it was held.
    w_wr        = r_hold_valid && r_hold_final;
    w_wr_arg3   = r_hold_arg3;
    // A sop inside a packet restarts the count at 1.
    w_cnt_inc   = (r_state == S_PKT && !in_sop) ? r_cnt + CW'(1) : CW'(1);
    if (w_acc) begin
      case (r_state)
        S_DROP: begin
          w_drop = 1'b1;
          if (in_eop) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        S_IDLE, S_PKT: begin
          if (r_state == S_IDLE && !in_sop) begin
            w_drop = 1'b1;
          end else begin
            if (r_state == S_PKT && in_sop) begin
              // Unterminated packet: close it on the flit we are still holding.
              w_wr_arg3   = {6'd0, 1'b1, r_hold_arg3[0]};
              w_trunc_inc = w_trunc_inc + 2'd1;
            end else begin
              w_wr_arg3 = r_hold_arg3;
            end
            // The new flit displaces whatever is held.
            w_wr      = r_hold_valid;
            w_load    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (in_eop) begin
              w_ld_final  = 1'b1;
              w_state_nxt = S_IDLE;
            end else if (w_cnt_inc == CNT_CAP) begin
              w_ld_final  = 1'b1;
              w_ld_arg3   = {6'd0, 1'b1, in_sop};
              w_trunc_inc = w_trunc_inc + 2'd1;
              w_state_nxt = S_DROP;
            end else begin
              w_state_nxt = S_PKT;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Hold register: one-flit lookahead so eop can be forced onto it
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_hold_valid <= 1'b0;
      r_hold_final <= 1'b0;
      r_hold_arg3  <= 8'd0;
      r_hold_data  <= '0;
    end else if (w_load) begin
      r_hold_valid <= 1'b1;
      r_hold_final <= w_ld_final;
      r_hold_arg3  <= w_ld_arg3;
      r_hold_data  <= in_data;
    end else if (w_wr) begin
      r_hold_valid <= 1'b0;
      r_hold_final <= 1'b0;
    end
  end

  // FIFO storage (contents need no reset; pointers qualify them)
  always_ff @(posedge Clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_wr_arg3, r_hold_data};
    end
  end

  // FIFO pointers, occupancy and registered in_ready
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_fifo_cnt <= w_fifo_cnt_nxt;
      // Two free slots cover one accepted flit plus the final-flit flush.
      r_in_ready <= (w_fifo_cnt_nxt <= READY_MAX);
    end
  end

  // Output stage: pop one entry per cycle when the sink has room
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_eth_tx   <= 1'b0;
      r_eth_data <= '0;
      r_eth_arg3 <= 8'd0;
    end else begin
      r_eth_tx <= w_pop;
      if (w_pop) begin
        {r_eth_arg3, r_eth_data} <= r_mem[r_rd_ptr];
      end
    end
  end

  // Event counters (wrap naturally at 2^32)
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_stat_pkts  <= 32'd0;
      r_stat_drop  <= 32'd0;
      r_stat_trunc <= 32'd0;
    end else begin
      if (w_pop && r_mem[r_rd_ptr][DATA_WIDTH+1]) begin
        r_stat_pkts <= r_stat_pkts + 32'd1;
      end
      if (w_drop) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
      r_stat_trunc <= r_stat_trunc + {30'd0, w_trunc_inc};
    end
  end

  assign in_ready        = r_in_ready;
  assign eth_tx          = r_eth_tx;
  assign eth_data        = r_eth_data;
  assign eth_arg3        = r_eth_arg3;
  assign stat_pkts       = r_stat_pkts;
  assign stat_drop_flits = r_stat_drop;
  assign stat_trunc      = r_stat_trunc;

endmodule
